breakout_game_ctrl: RTL and testbench



---
 rtl/breakout_game_ctrl_pkg.sv | 29 ++
 rtl/breakout_game_ctrl_bcd_add_sat.sv | 40 ++++
 rtl/breakout_game_ctrl.sv | 153 +++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_game_ctrl_pkg.sv
// Shared definitions for the breakout game controller: state encodings reused by
// the graph and text units, plus a timer-width helper.
package breakout_game_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_NEWGAME = 2'b00;
    localparam logic [STATE_W-1:0] ST_PLAY    = 2'b01;
    localparam logic [STATE_W-1:0] ST_NEWBALL = 2'b10;
    localparam logic [STATE_W-1:0] ST_OVER    = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        StNewgame = ST_NEWGAME,
        StPlay    = ST_PLAY,
        StNewball = ST_NEWBALL,
        StOver    = ST_OVER
    } game_state_e;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    function automatic int unsigned timer_width(int unsigned a, int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/breakout_game_ctrl_bcd_add_sat.sv
// Combinational saturating add of a single BCD digit to an N-digit BCD value,
// plus a magnitude compare of that value against a second BCD operand.
module bcd_add_sat
    import breakout_game_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [3:0]          addend,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] sum,
    output logic                gt
);

    logic [4*DIGITS-1:0] raw;
    logic [4:0]          t;
    logic                carry;

    always_comb begin
        raw   = '0;
        t     = '0;
        carry = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            t = 5'(a[4*i +: 4]) + 5'((i == 0) ? addend : 4'd0) + 5'(carry);
            if (t > 5'(BCD_MAX_DIGIT)) begin
                raw[4*i +: 4] = 4'(t - 5'd10);
                carry         = 1'b1;
            end else begin
                raw[4*i +: 4] = t[3:0];
                carry         = 1'b0;
            end
        end
        // Carry out of the top digit means we passed all-9s: clamp.
        sum = carry ? {DIGITS{BCD_MAX_DIGIT}} : raw;
    end

    // Valid BCD orders the same as plain binary, MSD first.
    assign gt = (a > b);

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game control: game FSM, saturating BCD score, high score, ball count
// and freeze timers, driven by rising edges of the start/hit/miss/cleared levels.
module breakout_game_ctrl
    import breakout_game_ctrl_pkg::*;
#(
    parameter int unsigned SCORE_DIGITS  = 4,
    parameter int unsigned BALLS         = 3,
    parameter int unsigned HIT_POINTS    = 1,
    parameter int unsigned NEWBALL_DELAY = 25000000,
    parameter int unsigned OVER_DELAY    = 100000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      hit,
    input  logic                      miss,
    input  logic                      cleared,
    output logic [STATE_W-1:0]        state,
    output logic                      gra_still,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [4*SCORE_DIGITS-1:0] high_score,
    output logic [3:0]                balls_left,
    output logic                      win
);

    localparam int unsigned SW     = 4 * SCORE_DIGITS;
    localparam int unsigned TimerW = timer_width(NEWBALL_DELAY, OVER_DELAY);
    localparam logic [TimerW-1:0] NbLoad   = TimerW'(NEWBALL_DELAY - 1);
    localparam logic [TimerW-1:0] OverLoad = TimerW'(OVER_DELAY - 1);

    logic start_q, hit_q, miss_q, cleared_q;
    logic start_rise, hit_rise, miss_rise, cleared_rise;

    game_state_e       state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [SW-1:0]     score_q, score_d;
    logic [SW-1:0]     high_q, high_d;
    logic [3:0]        balls_q, balls_d;
    logic              win_q, win_d;
    logic              still_q;

    logic [SW-1:0]     score_sum;
    logic              score_gt;

    assign start_rise   = start & ~start_q;
    assign hit_rise     = hit & ~hit_q;
    assign miss_rise    = miss & ~miss_q;
    assign cleared_rise = cleared & ~cleared_q;

    bcd_add_sat #(
        .DIGITS (SCORE_DIGITS)
    ) u_bcd_add_sat (
        .a      (score_q),
        .addend (4'(HIT_POINTS)),
        .b      (high_q),
        .sum    (score_sum),
        .gt     (score_gt)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        score_d = score_q;
        high_d  = high_q;
        balls_d = balls_q;
        win_d   = win_q;
        unique case (state_q)
            StNewgame: begin
                if (start_rise) begin
                    state_d = StPlay;
                    score_d = '0;
                    balls_d = 4'(BALLS);
                    win_d   = 1'b0;
                end
            end
            StPlay: begin
                if (hit_rise) begin
                    score_d = score_sum;
                end
                if (cleared_rise) begin
                    state_d = StOver;
                    win_d   = 1'b1;
                    timer_d = OverLoad;
                end else if (miss_rise) begin
                    if (balls_q > 4'd1) begin
                        balls_d = balls_q - 4'd1;
                        state_d = StNewball;
                        timer_d = NbLoad;
                    end else begin
                        balls_d = 4'd0;
                        state_d = StOver;
                        win_d   = 1'b0;
                        timer_d = OverLoad;
                    end
                end
            end
            StNewball: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TimerW'(1);
                end else if (start_rise) begin
                    state_d = StPlay;
                end
            end
            StOver: begin
                // Score is frozen in over, so comparing every cycle equals the entry check.
                if (score_gt) begin
                    high_d = score_q;
                end
                if (timer_q == '0) begin
                    state_d = StNewgame;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q   <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            cleared_q <= 1'b0;
            state_q   <= StNewgame;
            timer_q   <= '0;
            score_q   <= '0;
            high_q    <= '0;
            balls_q   <= 4'(BALLS);
            win_q     <= 1'b0;
            still_q   <= 1'b1;
        end else begin
            start_q   <= start;
            hit_q     <= hit;
            miss_q    <= miss;
            cleared_q <= cleared;
            state_q   <= state_d;
            timer_q   <= timer_d;
            score_q   <= score_d;
            high_q    <= high_d;
            balls_q   <= balls_d;
            win_q     <= win_d;
            still_q   <= (state_d != StPlay);
        end
    end

    assign state      = state_q;
    assign gra_still  = still_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign balls_left = balls_q;
    assign win        = win_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench: three parameterisations of breakout_game_ctrl driven in lockstep
// and compared against an event-level reference model, plus directed scenario checks.
module tb_breakout_game_ctrl;

    localparam int ND = 3;

    int p_dig   [ND] = '{4, 4, 2};
    int p_balls [ND] = '{3, 3, 2};
    int p_hp    [ND] = '{1, 5, 7};
    int p_nb    [ND] = '{4, 4, 3};
    int p_od    [ND] = '{8, 8, 5};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, hit = 1'b0, miss = 1'b0, cleared = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]  st0, st1, st2;
    logic        gs0, gs1, gs2;
    logic [15:0] sc0, sc1, hs0, hs1;
    logic [7:0]  sc2, hs2;
    logic [3:0]  bl0, bl1, bl2;
    logic        wn0, wn1, wn2;

    breakout_game_ctrl #(
        .SCORE_DIGITS(4), .BALLS(3), .HIT_POINTS(1), .NEWBALL_DELAY(4), .OVER_DELAY(8)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .hit(hit), .miss(miss), .cleared(cleared),
        .state(st0), .gra_still(gs0), .score(sc0), .high_score(hs0), .balls_left(bl0), .win(wn0)
    );

    breakout_game_ctrl #(
        .SCORE_DIGITS(4), .BALLS(3), .HIT_POINTS(5), .NEWBALL_DELAY(4), .OVER_DELAY(8)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .hit(hit), .miss(miss), .cleared(cleared),
        .state(st1), .gra_still(gs1), .score(sc1), .high_score(hs1), .balls_left(bl1), .win(wn1)
    );

    breakout_game_ctrl #(
        .SCORE_DIGITS(2), .BALLS(2), .HIT_POINTS(7), .NEWBALL_DELAY(3), .OVER_DELAY(5)
    ) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .hit(hit), .miss(miss), .cleared(cleared),
        .state(st2), .gra_still(gs2), .score(sc2), .high_score(hs2), .balls_left(bl2), .win(wn2)
    );

    logic [7:0]  d_ctl   [ND];
    logic [31:0] d_score [ND];
    logic [31:0] d_high  [ND];
    assign d_ctl[0]   = {st0, gs0, bl0, wn0};
    assign d_ctl[1]   = {st1, gs1, bl1, wn1};
    assign d_ctl[2]   = {st2, gs2, bl2, wn2};
    assign d_score[0] = 32'(sc0);
    assign d_score[1] = 32'(sc1);
    assign d_score[2] = 32'(sc2);
    assign d_high[0]  = 32'(hs0);
    assign d_high[1]  = 32'(hs1);
    assign d_high[2]  = 32'(hs2);

    // Reference model: decimal score, states as game phases (0 newgame .. 3 over).
    int m_state [ND], m_score [ND], m_high [ND], m_balls [ND], m_win [ND], m_wait [ND];
    bit prev_s, prev_h, prev_m, prev_c;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_step();
        bit sr, hr, mr, cr;
        int smax;
        if (reset) begin
            for (int d = 0; d < ND; d++) begin
                m_state[d] = 0; m_score[d] = 0; m_high[d] = 0;
                m_balls[d] = p_balls[d]; m_win[d] = 0; m_wait[d] = 0;
            end
            prev_s = 0; prev_h = 0; prev_m = 0; prev_c = 0;
            return;
        end
        sr = start && !prev_s;
        hr = hit && !prev_h;
        mr = miss && !prev_m;
        cr = cleared && !prev_c;
        prev_s = start; prev_h = hit; prev_m = miss; prev_c = cleared;
        for (int d = 0; d < ND; d++) begin
            smax = (10 ** p_dig[d]) - 1;
            case (m_state[d])
                0: if (sr) begin
                    m_state[d] = 1; m_score[d] = 0; m_balls[d] = p_balls[d]; m_win[d] = 0;
                end
                1: begin
                    if (hr) m_score[d] = (m_score[d] + p_hp[d] > smax) ? smax : m_score[d] + p_hp[d];
                    if (cr) begin
                        m_state[d] = 3; m_win[d] = 1; m_wait[d] = p_od[d] - 1;
                    end else if (mr) begin
                        if (m_balls[d] > 1) begin
                            m_balls[d]--; m_state[d] = 2; m_wait[d] = p_nb[d] - 1;
                        end else begin
                            m_balls[d] = 0; m_state[d] = 3; m_win[d] = 0; m_wait[d] = p_od[d] - 1;
                        end
                    end
                end
                2: begin
                    if (m_wait[d] > 0) m_wait[d]--;
                    else if (sr) m_state[d] = 1;
                end
                default: begin
                    if (m_score[d] > m_high[d]) m_high[d] = m_score[d];
                    if (m_wait[d] == 0) m_state[d] = 0;
                    else m_wait[d]--;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        logic [7:0] ectl;
        for (int d = 0; d < ND; d++) begin
            ectl = {2'(m_state[d]), (m_state[d] != 1), 4'(m_balls[d]), (m_win[d] != 0)};
            check($sformatf("d%0d_ctl", d), 32'(d_ctl[d]), 32'(ectl));
            check($sformatf("d%0d_score", d), d_score[d], to_bcd(m_score[d]));
            check($sformatf("d%0d_high", d), d_high[d], to_bcd(m_high[d]));
        end
    endtask

    task automatic tick(input bit chk);
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk) compare_all();
    endtask

    task automatic hit_pulse(input bit chk);
        hit = 1'b1; tick(chk);
        hit = 1'b0; tick(chk);
    endtask

    task automatic start_pulse();
        start = 1'b1; tick(1);
        start = 1'b0; tick(1);
    endtask

    // Lose a ball; optionally wait out the freeze and serve again.
    task automatic lose_ball(input bit serve);
        miss = 1'b1; tick(1);
        miss = 1'b0;
        if (serve) begin
            repeat (4) tick(1);
            start_pulse();
        end
    endtask

    initial begin
        tick(1);
        tick(1);
        check("rst_state", 32'(st0), 32'h0);
        check("rst_still", 32'(gs0), 32'h1);
        check("rst_balls", 32'(bl0), 32'h3);
        reset = 1'b0;

        // Scenario 1: serve
        start = 1'b1; tick(1);
        check("s1_state", 32'(st0), 32'h1);
        check("s1_still", 32'(gs0), 32'h0);
        check("s1_score", 32'(sc0), 32'h0);
        start = 1'b0; tick(1);

        // Scenario 2: separate hits, then a held hit counts once
        repeat (10) hit_pulse(1);
        check("s2_score10", 32'(sc0), 32'h0010);
        check("s2_score10_hp5", 32'(sc1), 32'h0050);
        hit = 1'b1;
        repeat (5) tick(1);
        hit = 1'b0; tick(1);
        check("s2_held", 32'(sc0), 32'h0011);

        // Scenario 4: miss, early start ignored, late start serves
        miss = 1'b1; tick(1);
        check("s4_state_nb", 32'(st0), 32'h2);
        check("s4_balls", 32'(bl0), 32'h2);
        miss = 1'b0; start = 1'b1; tick(1);
        check("s4_early_start", 32'(st0), 32'h2);
        start = 1'b0; tick(1); tick(1);
        start = 1'b1; tick(1);
        check("s4_late_start", 32'(st0), 32'h1);
        start = 1'b0; tick(1);

        // Scenario 5: reach 42, lose the remaining balls, high score latches
        repeat (31) hit_pulse(1);
        check("s5_score42", 32'(sc0), 32'h0042);
        lose_ball(1);
        lose_ball(0);
        check("s5_state_over", 32'(st0), 32'h3);
        check("s5_balls0", 32'(bl0), 32'h0);
        check("s5_win0", 32'(wn0), 32'h0);
        tick(1);
        check("s5_high42", 32'(hs0), 32'h0042);
        repeat (7) tick(1);
        check("s5_back_newgame", 32'(st0), 32'h0);
        check("s5_score_kept", 32'(sc0), 32'h0042);
        start_pulse();
        repeat (30) hit_pulse(1);
        lose_ball(1);
        lose_ball(1);
        lose_ball(0);
        repeat (9) tick(1);
        check("s5_high_kept", 32'(hs0), 32'h0042);
        check("s5_score30", 32'(sc0), 32'h0030);

        // Scenario 6: simultaneous events, then reset during over
        start_pulse();
        hit = 1'b1; miss = 1'b1; cleared = 1'b1; tick(1);
        check("s6_score", 32'(sc0), 32'h0001);
        check("s6_state", 32'(st0), 32'h3);
        check("s6_win", 32'(wn0), 32'h1);
        check("s6_balls", 32'(bl0), 32'h3);
        hit = 1'b0; miss = 1'b0; cleared = 1'b0; tick(1);
        reset = 1'b1; tick(1);
        check("s6_rst_high", 32'(hs0), 32'h0);
        check("s6_rst_state", 32'(st0), 32'h0);
        reset = 1'b0;

        // Randomised play against the model
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom % 6) == 0;
            hit     = ($urandom % 3) == 0;
            miss    = ($urandom % 12) == 0;
            cleared = ($urandom % 40) == 0;
            reset   = ($urandom % 500) == 0;
            tick(1);
        end
        start = 1'b0; hit = 1'b0; miss = 1'b0; cleared = 1'b0;

        // Scenario 3: saturation
        reset = 1'b1; tick(1);
        reset = 1'b0;
        start_pulse();
        repeat (9998) hit_pulse(0);
        compare_all();
        check("s3_score9998", 32'(sc0), 32'h9998);
        for (int i = 0; i < 3; i++) begin
            hit_pulse(1);
            check("s3_sat", 32'(sc0), 32'h9999);
        end
        check("s3_sat_2dig", 32'(sc2), 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
